// File: rtl/dcache_mem_bridge_pkg.sv
// Shared constants for the dcache memory-side bridge:
// FSM state encodings and bus burst-length helpers.
package dcache_mem_bridge_pkg;

  localparam int BUS_LEN_W = 8;
  localparam int STATE_W   = 3;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_R_REQ  = 3'd1;
  localparam logic [STATE_W-1:0] S_R_DATA = 3'd2;
  localparam logic [STATE_W-1:0] S_W_REQ  = 3'd3;
  localparam logic [STATE_W-1:0] S_W_WAIT = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE   = 3'd5;

  function automatic logic [BUS_LEN_W-1:0] burst_len(input int words);
    return BUS_LEN_W'(words - 1);
  endfunction

endpackage

// File: rtl/dcache_mem_bridge_line_buf.sv
// Line assembly buffer: word-indexed write, full-line read,
// synchronous clear.
module dcache_line_buf #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         clr_i,
  input  logic                         we_i,
  input  logic [IDX_W-1:0]             idx_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W*LINE_WORDS-1:0] line_o
);

  logic [DATA_W-1:0] words_q [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else if (we_i) begin
      words_q[idx_i] <= wdata_i;
    end
  end

  always_comb begin
    line_o = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      line_o[i*DATA_W +: DATA_W] = words_q[i];
    end
  end

endmodule

// File: rtl/dcache_mem_bridge.sv
// Memory-side bridge behind the dcache FSM: line refill bursts
// and single-word write-through, ending in a one-cycle ready pulse.
module dcache_mem_bridge
  import dcache_mem_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_valid,
  input  logic                         mem_for_store,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_wdata,
  input  logic [3:0]                   mem_wstrb,
  output logic                         mem_ready,
  output logic [DATA_W*LINE_WORDS-1:0] mem_rline,
  output logic                         bus_req,
  output logic                         bus_wr,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [BUS_LEN_W-1:0]         bus_len,
  output logic [DATA_W-1:0]            bus_wdata,
  output logic [3:0]                   bus_wstrb,
  input  logic                         bus_addr_ok,
  input  logic                         bus_rvalid,
  input  logic [DATA_W-1:0]            bus_rdata,
  input  logic                         bus_rlast,
  input  logic                         bus_wdone,
  output logic                         proto_err
);

  localparam int LINE_W = DATA_W * LINE_WORDS;
  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WOFF_W = $clog2(DATA_W / 8);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_WORDS - 1);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [IDX_W-1:0]     beat_q, beat_d;
  logic                 req_q, req_d;
  logic                 wr_q, wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BUS_LEN_W-1:0] len_q, len_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic                 err_q, err_d;
  logic                 buf_clr, buf_we;
  logic [LINE_W-1:0]    line;
  logic                 unused_addr;

  assign unused_addr = ^mem_addr[WOFF_W-1:0];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    err_d   = err_q;
    buf_clr = 1'b0;
    buf_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          req_d = 1'b1;
          wr_d  = mem_for_store;
          if (mem_for_store) begin
            addr_d  = {mem_addr[ADDR_W-1:WOFF_W], {WOFF_W{1'b0}}};
            len_d   = burst_len(1);
            wdata_d = mem_wdata;
            wstrb_d = mem_wstrb;
            state_d = S_W_REQ;
          end else begin
            addr_d  = {mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            len_d   = burst_len(LINE_WORDS);
            wdata_d = '0;
            wstrb_d = '0;
            buf_clr = 1'b1;
            state_d = S_R_REQ;
          end
        end
      end
      S_R_REQ: begin
        if (bus_addr_ok) begin
          req_d   = 1'b0;
          beat_d  = '0;
          state_d = S_R_DATA;
        end
      end
      S_R_DATA: begin
        if (bus_rvalid) begin
          buf_we = 1'b1;
          // rlast must coincide exactly with the final counted beat
          if (bus_rlast != (beat_q == LAST)) err_d = 1'b1;
          if (beat_q == LAST) state_d = S_DONE;
          else beat_d = beat_q + 1'b1;
        end
      end
      S_W_REQ: begin
        if (bus_addr_ok) begin
          req_d   = 1'b0;
          state_d = bus_wdone ? S_DONE : S_W_WAIT;
        end
      end
      S_W_WAIT: begin
        if (bus_wdone) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
    end
  end

  dcache_line_buf #(
    .DATA_W    (DATA_W),
    .LINE_WORDS(LINE_WORDS),
    .IDX_W     (IDX_W)
  ) u_line_buf (
    .clk    (clk),
    .clr_i  (rst | buf_clr),
    .we_i   (buf_we),
    .idx_i  (beat_q),
    .wdata_i(bus_rdata),
    .line_o (line)
  );

  assign mem_ready = (state_q == S_DONE);
  assign mem_rline = mem_ready ? line : '0;
  assign bus_req   = req_q;
  assign bus_wr    = wr_q;
  assign bus_addr  = addr_q;
  assign bus_len   = len_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge with an expected-completion
// queue popped on each mem_ready pulse.
module tb_dcache_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_valid, mem_for_store;
  logic [31:0]  mem_addr, mem_wdata;
  logic [3:0]   mem_wstrb;
  logic         mem_ready;
  logic [127:0] mem_rline;
  logic         bus_req, bus_wr;
  logic [31:0]  bus_addr;
  logic [7:0]   bus_len;
  logic [31:0]  bus_wdata;
  logic [3:0]   bus_wstrb;
  logic         bus_addr_ok, bus_rvalid, bus_rlast, bus_wdone;
  logic [31:0]  bus_rdata;
  logic         proto_err;

  typedef struct {
    logic         is_load;
    logic [127:0] line;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   p0;

  always #5 clk = ~clk;

  dcache_mem_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_for_store(mem_for_store),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rline    (mem_rline),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_len      (bus_len),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_addr_ok  (bus_addr_ok),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata),
    .bus_rlast    (bus_rlast),
    .bus_wdone    (bus_wdone),
    .proto_err    (proto_err)
  );

  always @(negedge clk) if (mem_ready === 1'b1) pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"},   bus_req,   0);
    chk({tag, "_wr"},    bus_wr,    0);
    chk({tag, "_addr"},  bus_addr,  0);
    chk({tag, "_len"},   bus_len,   0);
    chk({tag, "_wdata"}, bus_wdata, 0);
    chk({tag, "_wstrb"}, bus_wstrb, 0);
    chk({tag, "_ready"}, mem_ready, 0);
    chk({tag, "_rline"}, mem_rline, 0);
    chk({tag, "_err"},   proto_err, 0);
  endtask

  task automatic wait_ready(input int max);
    int   k = 0;
    exp_t e;
    while (mem_ready !== 1'b1 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("ready", mem_ready, 1);
    if (mem_ready === 1'b1) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.is_load) chk("rline", mem_rline, e.line);
      end
    end
    mem_valid = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", mem_ready, 0);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [127:0] ln,
                         input int gap, input int last_at,
                         input int aok_wait, input bit stale);
    exp_t e;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_for_store = 1'b0;
    mem_addr = a;
    e.is_load = 1'b1;
    e.line = ln;
    sb.push_back(e);
    @(negedge clk);
    mem_addr = ~a;
    chk("rd_req", bus_req, 1);
    chk("rd_wr", bus_wr, 0);
    chk("rd_addr", bus_addr, a & 32'hFFFF_FFF0);
    chk("rd_len", bus_len, 3);
    repeat (aok_wait) @(negedge clk);
    chk("rd_req_held", bus_req, 1);
    bus_addr_ok = 1'b1;
    if (stale) begin
      bus_rvalid = 1'b1;
      bus_rdata = 32'hBAD0_BAD0;
      bus_rlast = 1'b1;
    end
    @(negedge clk);
    bus_addr_ok = 1'b0;
    bus_rvalid = 1'b0;
    bus_rlast = 1'b0;
    chk("rd_req_drop", bus_req, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      bus_rvalid = 1'b1;
      bus_rdata = ln[i*32 +: 32];
      bus_rlast = (i == last_at);
      @(negedge clk);
      bus_rvalid = 1'b0;
      bus_rlast = 1'b0;
    end
    wait_ready(0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input bit same);
    exp_t e;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_for_store = 1'b1;
    mem_addr = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    e.is_load = 1'b0;
    e.line = '0;
    sb.push_back(e);
    @(negedge clk);
    chk("wr_req", bus_req, 1);
    chk("wr_wr", bus_wr, 1);
    chk("wr_addr", bus_addr, a & 32'hFFFF_FFFC);
    chk("wr_len", bus_len, 0);
    chk("wr_wdata", bus_wdata, wd);
    chk("wr_wstrb", bus_wstrb, ws);
    bus_addr_ok = 1'b1;
    bus_wdone = same;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    bus_wdone = 1'b0;
    if (!same) begin
      mem_addr = a ^ 32'h0000_0100;
      mem_wdata = ~wd;
      mem_wstrb = ~ws;
      repeat (2) @(negedge clk);
      chk("ww_no_req", bus_req, 0);
      chk("ww_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("ww_wdata", bus_wdata, wd);
      chk("ww_wstrb", bus_wstrb, ws);
      chk("ww_not_ready", mem_ready, 0);
      bus_wdone = 1'b1;
      @(negedge clk);
      bus_wdone = 1'b0;
    end
    wait_ready(0);
  endtask

  initial begin
    rst = 1'b1;
    mem_valid = 1'b0;
    mem_for_store = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    bus_addr_ok = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    bus_rlast = 1'b0;
    bus_wdone = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    do_load(32'h1C0, {32'hDDDD_0004, 32'hCCCC_0003,
                      32'hBBBB_0002, 32'hAAAA_0001}, 0, 3, 1, 1'b0);
    chk("t1_err", proto_err, 0);

    do_store(32'h1C4, 32'hDEAD_BEEF, 4'h3, 1'b1);

    do_load(32'h2A8, {32'h4444_4444, 32'h3333_3333,
                      32'h2222_2222, 32'h1111_1111}, 1, 1, 0, 1'b0);
    chk("t3_err", proto_err, 1);

    @(negedge clk);
    mem_valid = 1'b1;
    mem_for_store = 1'b0;
    mem_addr = 32'h200;
    @(negedge clk);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 32'h0BAD_0000;
    @(negedge clk);
    bus_rdata = 32'h0BAD_0001;
    @(negedge clk);
    bus_rvalid = 1'b0;
    rst = 1'b1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 32'hBAD0_0002;
    bus_rlast = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_rlast = 1'b0;
    chk("stale_no_req", bus_req, 0);
    chk("stale_no_ready", mem_ready, 0);
    chk("stale_no_err", proto_err, 0);
    do_load(32'h24C, {32'h8888_0008, 32'h7777_0007,
                      32'h6666_0006, 32'h5555_0005}, 0, 3, 0, 1'b1);
    chk("t4_err", proto_err, 0);

    #1 p0 = pulses;
    do_store(32'h304, 32'h1234_5678, 4'hF, 1'b0);
    #1 chk("t5_pulses", pulses - p0, 1);

    p0 = pulses;
    do_load(32'h3F0, {32'hCAFE_0003, 32'hCAFE_0002,
                      32'hCAFE_0001, 32'hCAFE_0000}, 0, 3, 0, 1'b0);
    do_store(32'h3FA, 32'h0F0F_0F0F, 4'hC, 1'b1);
    repeat (3) @(negedge clk);
    #1 chk("t6_pulses", pulses - p0, 2);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
